// File: rtl/approx_err_monitor.sv
// Measures the error of an 8x8 approximate multiplier over a fixed-length run of samples.
// A sample is registered, compared with the exact product, then accumulated; results are held in DONE until the next start.
module approx_err_monitor #(
  parameter int NUM_SAMPLES = 256,
  parameter int SUM_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [15:0]      in_y,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] err_sum,
  output logic [15:0]      err_max,
  output logic [15:0]      err_cnt,
  output logic [15:0]      sample_cnt
);

  localparam logic [15:0] NS = 16'(NUM_SAMPLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  logic   busy_q, done_q;

  logic             s1_vld_q, s1_vld_d;
  logic [7:0]       a_q, a_d, b_q, b_d;
  logic [15:0]      y_q, y_d;
  logic             s2_vld_q, s2_vld_d;
  logic [15:0]      ed_q, ed_d;
  logic [SUM_W-1:0] err_sum_q, err_sum_d;
  logic [15:0]      err_max_q, err_max_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic [15:0]      sample_cnt_q, sample_cnt_d;

  logic             xfer;
  logic             start_ok;
  logic [15:0]      exact;
  logic signed [16:0] diff, diff_neg;
  logic [SUM_W:0]   sum_ext;

  assign in_ready = busy_q && (sample_cnt_q < NS);
  assign xfer     = in_valid && in_ready;
  assign start_ok = start && (state_q != RUN);

  assign exact    = {8'd0, a_q} * {8'd0, b_q};
  assign diff     = $signed({1'b0, exact}) - $signed({1'b0, y_q});
  assign diff_neg = -diff;
  assign sum_ext  = {1'b0, err_sum_q} + {{(SUM_W - 15){1'b0}}, ed_q};

  always_comb begin
    s1_vld_d     = xfer;
    a_d          = a_q;
    b_d          = b_q;
    y_d          = y_q;
    s2_vld_d     = s1_vld_q;
    ed_d         = ed_q;
    err_sum_d    = err_sum_q;
    err_max_d    = err_max_q;
    err_cnt_d    = err_cnt_q;
    sample_cnt_d = sample_cnt_q;

    if (xfer) begin
      a_d          = in_a;
      b_d          = in_b;
      y_d          = in_y;
      sample_cnt_d = sample_cnt_q + 16'd1;
    end

    if (s1_vld_q) begin
      ed_d = diff[16] ? diff_neg[15:0] : diff[15:0];
    end

    if (s2_vld_q) begin
      err_sum_d = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
      if (ed_q > err_max_q) begin
        err_max_d = ed_q;
      end
      if (ed_q != 16'd0 && err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end

    // A new run wipes the previous results on the same edge it enters RUN.
    if (start_ok) begin
      s1_vld_d     = 1'b0;
      s2_vld_d     = 1'b0;
      err_sum_d    = '0;
      err_max_d    = '0;
      err_cnt_d    = '0;
      sample_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q     <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      y_q          <= '0;
      s2_vld_q     <= 1'b0;
      ed_q         <= '0;
      err_sum_q    <= '0;
      err_max_q    <= '0;
      err_cnt_q    <= '0;
      sample_cnt_q <= '0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      a_q          <= a_d;
      b_q          <= b_d;
      y_q          <= y_d;
      s2_vld_q     <= s2_vld_d;
      ed_q         <= ed_d;
      err_sum_q    <= err_sum_d;
      err_max_q    <= err_max_d;
      err_cnt_q    <= err_cnt_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  // DONE is entered only after the last sample has left both pipeline stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          if (sample_cnt_q == NS && !s1_vld_q && !s2_vld_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err_sum    = err_sum_q;
  assign err_max    = err_max_q;
  assign err_cnt    = err_cnt_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed bench for approx_err_monitor with NUM_SAMPLES=4, SUM_W=16.
module tb_approx_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a, in_b;
  logic [15:0] in_y;
  logic        busy, done;
  logic [15:0] err_sum, err_max, err_cnt, sample_cnt;

  int total = 0;
  int bad   = 0;

  approx_err_monitor #(.NUM_SAMPLES(4), .SUM_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_y       (in_y),
    .busy       (busy),
    .done       (done),
    .err_sum    (err_sum),
    .err_max    (err_max),
    .err_cnt    (err_cnt),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [15:0] y);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_y     = y;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("done_within_budget", {31'd0, done}, 32'd1);
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    repeat (3) step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_err_sum", {16'd0, err_sum}, 32'd0);
    chk("rst_sample_cnt", {16'd0, sample_cnt}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_no_ready", {31'd0, in_ready}, 32'd0);

    // Run 1: mixed errors back to back, done exactly 3 edges after the last transfer
    start_run();
    chk("run1_busy", {31'd0, busy}, 32'd1);
    chk("run1_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 8'd0, 8'd0, 16'd0);      step();
    drive(1'b1, 8'd255, 8'd255, 16'd65000); step();
    drive(1'b1, 8'd2, 8'd3, 16'd10);     step();
    drive(1'b1, 8'd15, 8'd15, 16'd225);  step();
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    chk("run1_ready_drop", {31'd0, in_ready}, 32'd0);
    chk("run1_sample_cnt", {16'd0, sample_cnt}, 32'd4);
    step();
    chk("run1_done_l1", {31'd0, done}, 32'd0);
    step();
    chk("run1_done_l2", {31'd0, done}, 32'd0);
    chk("run1_busy_l2", {31'd0, busy}, 32'd1);
    step();
    chk("run1_done_l3", {31'd0, done}, 32'd1);
    chk("run1_busy_l3", {31'd0, busy}, 32'd0);
    chk("run1_err_sum", {16'd0, err_sum}, 32'd29);
    chk("run1_err_max", {16'd0, err_max}, 32'd25);
    chk("run1_err_cnt", {16'd0, err_cnt}, 32'd2);
    drive(1'b1, 8'd9, 8'd9, 16'd0);
    repeat (3) step();
    chk("run1_hold_sum", {16'd0, err_sum}, 32'd29);
    chk("run1_hold_cnt", {16'd0, sample_cnt}, 32'd4);
    chk("run1_hold_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b0, 8'd0, 8'd0, 16'd0);

    // Run 2: start in DONE clears everything; toggled valid with exact y, then wrong y once full
    start_run();
    chk("run2_done_clr", {31'd0, done}, 32'd0);
    chk("run2_sum_clr", {16'd0, err_sum}, 32'd0);
    chk("run2_max_clr", {16'd0, err_max}, 32'd0);
    chk("run2_cnt_clr", {16'd0, sample_cnt}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive(1'b1, 8'(i * 17 + 3), 8'(i * 5 + 1), 16'((i * 17 + 3) * (i * 5 + 1)));
      else            drive(1'b1 ^ 1'b1, 8'd200, 8'd200, 16'd0);
      step();
    end
    chk("run2_sample_cnt", {16'd0, sample_cnt}, 32'd4);
    chk("run2_ready_low", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 8'd100, 8'd100, 16'd7);
    step();
    step();
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    wait_done();
    chk("run2_sample_final", {16'd0, sample_cnt}, 32'd4);
    chk("run2_err_sum", {16'd0, err_sum}, 32'd0);
    chk("run2_err_cnt", {16'd0, err_cnt}, 32'd0);

    // Run 3: saturation of the 16-bit accumulator, with a start pulse ignored mid-run
    start_run();
    drive(1'b1, 8'd200, 8'd200, 16'd0); step();
    drive(1'b1, 8'd200, 8'd200, 16'd0); step();
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run3_start_ignored_busy", {31'd0, busy}, 32'd1);
    chk("run3_start_ignored_cnt", {16'd0, sample_cnt}, 32'd2);
    chk("run3_partial_sum", {16'd0, err_sum}, 32'd40000);
    drive(1'b1, 8'd200, 8'd200, 16'd0); step();
    drive(1'b1, 8'd200, 8'd200, 16'd0); step();
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    wait_done();
    chk("run3_err_sum_sat", {16'd0, err_sum}, 32'd65535);
    chk("run3_err_max", {16'd0, err_max}, 32'd40000);
    chk("run3_err_cnt", {16'd0, err_cnt}, 32'd4);

    // Run 4: reset mid-run discards in-flight samples
    start_run();
    drive(1'b1, 8'd255, 8'd255, 16'd0); step();
    drive(1'b1, 8'd255, 8'd255, 16'd0); step();
    drive(1'b1, 8'd255, 8'd255, 16'd0);
    rst_n = 1'b0;
    #1;
    chk("rst4_busy", {31'd0, busy}, 32'd0);
    chk("rst4_ready", {31'd0, in_ready}, 32'd0);
    chk("rst4_sum", {16'd0, err_sum}, 32'd0);
    chk("rst4_sample_cnt", {16'd0, sample_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("rst4_stay_idle", {31'd0, busy}, 32'd0);
    chk("rst4_no_accum", {16'd0, err_sum}, 32'd0);
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    start_run();
    drive(1'b1, 8'd10, 8'd10, 16'd90);   step();
    drive(1'b1, 8'd3, 8'd4, 16'd12);     step();
    drive(1'b1, 8'd100, 8'd2, 16'd250);  step();
    drive(1'b1, 8'd1, 8'd1, 16'd0);      step();
    drive(1'b0, 8'd0, 8'd0, 16'd0);
    wait_done();
    chk("run4_err_sum", {16'd0, err_sum}, 32'd61);
    chk("run4_err_max", {16'd0, err_max}, 32'd50);
    chk("run4_err_cnt", {16'd0, err_cnt}, 32'd3);
    chk("run4_sample_cnt", {16'd0, sample_cnt}, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/approx_err_monitor.md
APPROX_ERR_MONITOR -- requirements
Module: approx_err_monitor

Interface
REQ-001 Parameter NUM_SAMPLES, default 256, meaning the number of accepted samples per measurement run; the legal range SHALL be 1..65535.
REQ-002 Parameter SUM_W, default 32, meaning the width of the error-distance accumulator; the legal range SHALL be 16..48.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  single-cycle request to begin a run.
REQ-006 in_valid  input  1  sample present on in_a, in_b, in_y.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 in_a, in_b  input  8 each  multiplier operands, unsigned.
REQ-009 in_y  input  16  approximate product from the 8x8 approximate multiplier for in_a, in_b.
REQ-010 busy  output  1  run in progress, including pipeline drain.
REQ-011 done  output  1  results valid; held high until the next start or reset.
REQ-012 err_sum  output  SUM_W  sum of error distances, saturating.
REQ-013 err_max  output  16  largest error distance seen in the run.
REQ-014 err_cnt  output  16  number of samples with a nonzero error distance.
REQ-015 sample_cnt  output  16  number of samples accepted in the run.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE; it SHALL reset to IDLE.
REQ-017 IDLE or DONE with start=1 SHALL go to RUN next cycle and clear err_sum, err_max, err_cnt, sample_cnt and done in that same edge.
REQ-018 start while in RUN SHALL be ignored.
REQ-019 in_ready SHALL be 1 only in RUN while sample_cnt < NUM_SAMPLES; a transfer SHALL occur when in_valid and in_ready are both 1.
REQ-020 in_valid without in_ready SHALL not be counted or accumulated; operands need not be held stable.
REQ-021 Stage 1 (transfer edge): the block SHALL register a, b and y, and increment sample_cnt.
REQ-022 Stage 2 (next edge): the block SHALL register exact = a*b (16-bit, unsigned) and ED = |exact - y|, computed with 17-bit signed arithmetic so ED fits in 16 bits.
REQ-023 Stage 3 (next edge): err_sum SHALL take the saturating value err_sum+ED, clamped at 2^SUM_W-1; err_max SHALL become max(err_max, ED); err_cnt SHALL increment if ED≠0 (saturating at 65535).
REQ-024 Back-to-back transfers SHALL be supported with one sample per cycle and no bubbles.
REQ-025 When sample_cnt reaches NUM_SAMPLES, in_ready SHALL drop on the same edge; RUN→DONE SHALL occur once stages 2 and 3 are empty; done SHALL rise exactly 3 cycles after the last transfer edge.
REQ-026 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-027 In DONE, all result outputs SHALL hold stable and in_ready SHALL be 0.
REQ-028 start in DONE SHALL begin a new run per REQ-017; results of the previous run SHALL then be lost.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE; in_ready, busy and done SHALL go to 0; err_sum, err_max, err_cnt and sample_cnt SHALL go to 0; all pipeline valid flags SHALL clear.
REQ-030 Reset mid-run SHALL discard in-flight samples; after release the block SHALL stay in IDLE until start.
REQ-031 Release of rst_n SHALL be synchronous to clk in the system; the block SHALL add no synchronizer.

Verification
REQ-032 NUM_SAMPLES=4, start, then samples (0,0,0), (255,255,65000), (2,3,10), (15,15,225) back-to-back -> err_sum=29, err_max=25, err_cnt=2, sample_cnt=4, done high 3 cycles after the 4th transfer.
REQ-033 Toggle in_valid 1/0 with NUM_SAMPLES=3 and all y exact -> exactly 3 transfers, err_sum=0, err_cnt=0, in_ready low after the 3rd.
REQ-034 SUM_W=16, NUM_SAMPLES=2, two samples (200,200,0) each with ED=40000 -> err_sum=65535 (saturated), err_max=40000.
REQ-035 Pulse rst_n low after 2 of 4 samples -> all outputs 0, state IDLE; a new start with 4 samples gives results of those 4 only.
REQ-036 start asserted during RUN and in the DONE cycle -> ignored in RUN; in DONE, counters clear and a new run begins the next cycle.
REQ-037 Random 10,000 samples with y from the n8_L1 multiplier -> outputs match a reference model bit-exactly.
